// File: rtl/nand3_chip_tester.sv
// Built-in self-test sequencer for a triple 3-input NAND part: walks all eight
// input vectors, checks each gate output against ideal NAND, reports a verdict.
`timescale 1ns/1ps
module nand3_chip_tester #(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic       abort,
  output logic [8:0] dut_in,
  input  logic [2:0] dut_out,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] fail_mask,
  output logic [2:0] first_fail_vec
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    CHECK  = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic [3:0] CNT_LAST = 4'(SETTLE_CYCLES - 1);

  state_t     state_r, next_state_s;
  logic [2:0] v_r, v_nxt_s;
  logic [3:0] cnt_r, cnt_nxt_s;
  logic [8:0] dut_in_r, dut_in_nxt_s;
  logic       busy_r, busy_nxt_s;
  logic       done_r, done_nxt_s;
  logic       pass_r, pass_nxt_s;
  logic [2:0] fail_mask_r, fail_mask_nxt_s;
  logic [2:0] first_fail_r, first_fail_nxt_s;
  logic [2:0] mismatch_s;
  logic       settle_last_s;
  logic       go_s;

  function automatic logic expected_y(input logic [2:0] v);
    return (v == 3'd7) ? 1'b0 : 1'b1;
  endfunction

  // Case inequality makes an X/Z output from the part count as a mismatch.
  function automatic logic [2:0] mismatch_bits(input logic [2:0] y, input logic exp);
    logic [2:0] m;
    for (int k = 0; k < 3; k++) begin
      m[k] = (y[k] !== exp);
    end
    return m;
  endfunction

  function automatic logic [8:0] vector_drive(input logic [2:0] v);
    return {3{v}};
  endfunction

  assign mismatch_s    = mismatch_bits(dut_out, expected_y(v_r));
  assign settle_last_s = (cnt_r == CNT_LAST);
  assign go_s          = start & ~abort;

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state decode; abort only matters while a run is in flight
  always_comb begin
    next_state_s = IDLE;
    case (state_r)
      IDLE: begin
        if (go_s) next_state_s = SETTLE;
        else      next_state_s = IDLE;
      end
      SETTLE: begin
        if (abort)              next_state_s = IDLE;
        else if (settle_last_s) next_state_s = CHECK;
        else                    next_state_s = SETTLE;
      end
      CHECK: begin
        if (abort)             next_state_s = IDLE;
        else if (v_r == 3'd7)  next_state_s = DONE;
        else                   next_state_s = SETTLE;
      end
      DONE:    next_state_s = IDLE;
      default: next_state_s = IDLE;
    endcase
  end

  // Next values of the datapath and registered outputs
  always_comb begin
    v_nxt_s          = v_r;
    cnt_nxt_s        = cnt_r;
    dut_in_nxt_s     = dut_in_r;
    busy_nxt_s       = busy_r;
    done_nxt_s       = 1'b0;
    pass_nxt_s       = pass_r;
    fail_mask_nxt_s  = fail_mask_r;
    first_fail_nxt_s = first_fail_r;
    case (state_r)
      IDLE: begin
        if (go_s) begin
          v_nxt_s          = 3'd0;
          cnt_nxt_s        = 4'd0;
          dut_in_nxt_s     = vector_drive(3'd0);
          busy_nxt_s       = 1'b1;
          pass_nxt_s       = 1'b0;
          fail_mask_nxt_s  = 3'b000;
          first_fail_nxt_s = 3'd0;
        end else begin
          busy_nxt_s = 1'b0;
        end
      end
      SETTLE: begin
        if (abort) begin
          v_nxt_s      = 3'd0;
          cnt_nxt_s    = 4'd0;
          dut_in_nxt_s = 9'd0;
          busy_nxt_s   = 1'b0;
          pass_nxt_s   = 1'b0;
        end else if (settle_last_s) begin
          cnt_nxt_s = cnt_r;
        end else begin
          cnt_nxt_s = cnt_r + 4'd1;
        end
      end
      CHECK: begin
        if (abort) begin
          v_nxt_s      = 3'd0;
          cnt_nxt_s    = 4'd0;
          dut_in_nxt_s = 9'd0;
          busy_nxt_s   = 1'b0;
          pass_nxt_s   = 1'b0;
        end else begin
          fail_mask_nxt_s = fail_mask_r | mismatch_s;
          if ((fail_mask_r == 3'b000) && (mismatch_s != 3'b000)) begin
            first_fail_nxt_s = v_r;
          end else begin
            first_fail_nxt_s = first_fail_r;
          end
          cnt_nxt_s = 4'd0;
          if (v_r == 3'd7) begin
            v_nxt_s      = 3'd0;
            dut_in_nxt_s = 9'd0;
            busy_nxt_s   = 1'b0;
            done_nxt_s   = 1'b1;
            pass_nxt_s   = (fail_mask_nxt_s == 3'b000);
          end else begin
            v_nxt_s      = v_r + 3'd1;
            dut_in_nxt_s = vector_drive(v_r + 3'd1);
          end
        end
      end
      DONE: begin
        busy_nxt_s = 1'b0;
      end
      default: begin
        v_nxt_s      = 3'd0;
        cnt_nxt_s    = 4'd0;
        dut_in_nxt_s = 9'd0;
        busy_nxt_s   = 1'b0;
        pass_nxt_s   = 1'b0;
      end
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      v_r          <= 3'd0;
      cnt_r        <= 4'd0;
      dut_in_r     <= 9'd0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      pass_r       <= 1'b0;
      fail_mask_r  <= 3'b000;
      first_fail_r <= 3'd0;
    end else begin
      v_r          <= v_nxt_s;
      cnt_r        <= cnt_nxt_s;
      dut_in_r     <= dut_in_nxt_s;
      busy_r       <= busy_nxt_s;
      done_r       <= done_nxt_s;
      pass_r       <= pass_nxt_s;
      fail_mask_r  <= fail_mask_nxt_s;
      first_fail_r <= first_fail_nxt_s;
    end
  end

  assign dut_in         = dut_in_r;
  assign busy           = busy_r;
  assign done           = done_r;
  assign pass           = pass_r;
  assign fail_mask      = fail_mask_r;
  assign first_fail_vec = first_fail_r;

endmodule

// File: doc/nand3_chip_tester.md
# nand3_chip_tester

Built-in self-test sequencer for the triple 3-input NAND part model. It drives all eight input combinations onto the three gates simultaneously and holds each vector for a programmable settle time. It samples the three outputs, compares them against the ideal NAND result, and reports a pass/fail verdict with a per-gate fault mask. The block sits between a lab-board start button/LED bank and the device under test.

## Interface
- `SETTLE_CYCLES`, default 2: clock cycles in SETTLE per vector. Legal range is 1..15. Must exceed the gate DELAY in clock periods.
- `clk` input 1: single clock; all state changes on the rising edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `start` input 1: level sampled in IDLE; starts a run.
- `abort` input 1: synchronous; cancels a run in progress.
- `dut_in` output 9: gate inputs {c3,b3,a3,c2,b2,a2,c1,b1,a1}; registered.
- `dut_out` input 3: gate outputs {y3,y2,y1}.
- `busy` output 1: high while a run is in progress.
- `done` output 1: one-cycle pulse at the end of a completed run.
- `pass` output 1: high when the last completed run had no mismatch.
- `fail_mask` output 3: bit k is sticky-set when gate k+1 mismatched on any vector.
- `first_fail_vec` output 3: index of the first mismatching vector. Equals 0 when `fail_mask`==0.

## Operation
- States: IDLE, SETTLE, CHECK, DONE. A 3-bit vector index `v` and a 4-bit settle counter `cnt`.
- Vector v drives every gate with a=v[0], b=v[1], c=v[2]. So `dut_in` = {3{v[2],v[1],v[0]}}.
- Expected output per gate: 1 for v=0..6, 0 for v=7.
- IDLE to SETTLE, when start=1 and abort=0:
  - v←0, cnt←0, `dut_in`←vector 0, busy←1.
  - pass, fail_mask and first_fail_vec are cleared to 0.
- SETTLE: if cnt==SETTLE_CYCLES-1, go to CHECK; else cnt←cnt+1.
- CHECK: compare `dut_out` against the expected value at this edge. In simulation, any X/Z counts as a mismatch.
  - OR mismatch bits into fail_mask.
  - If this is the first mismatch of the run, first_fail_vec←v.
  - If v==7, go to DONE. Otherwise v←v+1, `dut_in`←next vector, cnt←0, go to SETTLE.
- DONE, one cycle:
  - done=1, busy=0, `dut_in`=0.
  - pass=(fail_mask==0). The new fail_mask is included in this evaluation.
  - Then return to IDLE.
- Results (pass, fail_mask, first_fail_vec) hold until the next accepted start.
- abort=1 in SETTLE or CHECK:
  - Next edge goes to IDLE with `dut_in`=0, busy=0, no done pulse, pass=0.
  - fail_mask and first_fail_vec keep partial results.
  - The comparison in an aborted CHECK cycle is discarded.
- abort in IDLE or DONE has no effect. start and abort together in IDLE: abort wins, stay IDLE.
- start while busy or in DONE is ignored. start held high in IDLE after DONE begins a new run.
- Reset values: state IDLE, v=0, cnt=0, `dut_in`=0, busy=0, done=0, pass=0, fail_mask=0, first_fail_vec=0.
- Reset asserted mid-run forces these values immediately. No done pulse follows.

## Timing
- Start accepted at edge E0. Vector 0 is valid from E0 for S+1 cycles (S=SETTLE_CYCLES).
- Vector n is applied at edge E0+n(S+1). It is sampled at edge E0+(n+1)(S+1).
- done is high in the cycle after edge E0+8(S+1). busy is high for exactly 8(S+1) cycles.
- With S=2: busy for 24 cycles, done in cycle 25 after start.
- All outputs are registered. `dut_out` is used only at CHECK edges, with no combinational path to outputs.

## Test plan
- Good-part run:
  - Setup: ideal NAND model with DELAY=10 ns, clk 100 MHz, S=2, reset held 5 cycles.
  - Stimulus: start pulse.
  - Required: `dut_in` steps 000…777 in octal per gate; busy 24 cycles; done pulse 25 cycles after start; pass=1, fail_mask=000, first_fail_vec=0.
- y2 stuck-at-1:
  - Required: done; pass=0, fail_mask=010, first_fail_vec=7.
- y1 stuck-at-0:
  - Required: pass=0, fail_mask=001, first_fail_vec=0.
- Slow part, DELAY=35 ns with S=2 (30 ns hold per vector):
  - Required: fail_mask=111, first_fail_vec=7.
- Same slow part with S=4:
  - Required: pass=1.
- Abort at cycle 10 after start:
  - Required: busy drops the next cycle; `dut_in`=0; no done; pass=0.
  - A following start completes normally with pass=1.
- Start re-pulsed while busy:
  - Required: ignored; done still occurs at cycle 25.
- reset_n low mid-run:
  - Required: all outputs 0 immediately, no done.
  - After release, start produces a normal run.
